// File: rtl/wb_trace_buffer_if.sv
// Drain-side stream of the write-back trace buffer: the head entry plus its valid/ready handshake.
interface wb_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic              out_ena;
  logic [4:0]        out_reg;
  logic [DATA_W-1:0] out_value;

  modport master (output out_valid, out_pc, out_ena, out_reg, out_value, input out_ready);
  modport slave  (input out_valid, out_pc, out_ena, out_reg, out_value, output out_ready);
endinterface

// File: rtl/wb_trace_buffer.sv
// Capture FIFO for the CPU write-back trace port: filtering, drop-newest or overwrite-oldest
// when full, occupancy flags and a saturating lost-event counter.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     debug_wb_have_inst,
  input  logic [PC_W-1:0]          debug_wb_pc,
  input  logic                     debug_wb_ena,
  input  logic [4:0]               debug_wb_reg,
  input  logic [DATA_W-1:0]        debug_wb_value,
  input  logic                     capture_en,
  input  logic                     cfg_only_wr,
  input  logic                     cfg_overwrite,
  wb_trace_buffer_if.master        out_if,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + 1 + 5 + DATA_W;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          q;
  logic          pop;
  logic          push;
  logic          drop;
  logic          discard;
  logic [EW-1:0] head;

  assign q = debug_wb_have_inst & capture_en &
             (~cfg_only_wr | (debug_wb_ena & (debug_wb_reg != 5'd0)));

  assign full             = (count == CNT_FULL);
  assign empty            = (count == '0);
  assign out_if.out_valid = ~empty;
  assign pop              = out_if.out_valid & out_if.out_ready;

  // A qualified event into a full FIFO with no pop is always a loss; in overwrite
  // mode the loss is the oldest entry, which the new one replaces in place.
  assign drop    = q & full & ~pop;
  assign discard = drop & cfg_overwrite;
  assign push    = q & (~full | pop | cfg_overwrite);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop | discard) rd_ptr <= rd_ptr + PTR_ONE;
      if (push & ~pop & ~discard) count <= count + CNT_ONE;
      else if (pop & ~push)       count <= count - CNT_ONE;
      if (drop && (drop_cnt != DROP_MAX)) drop_cnt <= drop_cnt + DROP_ONE;
    end
  end

  assign head = out_if.out_valid ? mem[rd_ptr] : '0;
  assign {out_if.out_pc, out_if.out_ena, out_if.out_reg, out_if.out_value} = head;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of the trace FIFO.
module tb_wb_trace_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hv = 1'b0, ena = 1'b0, ce = 1'b0, only = 1'b0, ow = 1'b0, rdy = 1'b0;
  logic [31:0] pc = '0, val = '0;
  logic [4:0]  rg = '0;

  logic [2:0]  count_a, count_b;
  logic        full_a, empty_a, full_b, empty_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  int vectors = 0;
  int miscompares = 0;

  wb_trace_buffer_if #(.PC_W(32), .DATA_W(32)) if_a ();
  wb_trace_buffer_if #(.PC_W(32), .DATA_W(32)) if_b ();
  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_have_inst(hv), .debug_wb_pc(pc), .debug_wb_ena(ena),
    .debug_wb_reg(rg), .debug_wb_value(val),
    .capture_en(ce), .cfg_only_wr(only), .cfg_overwrite(ow),
    .out_if(if_a), .count(count_a), .full(full_a), .empty(empty_a), .drop_cnt(drop_a)
  );

  // Narrow drop counter copy, fed identically, to exercise saturation.
  wb_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .debug_wb_have_inst(hv), .debug_wb_pc(pc), .debug_wb_ena(ena),
    .debug_wb_reg(rg), .debug_wb_value(val),
    .capture_en(ce), .cfg_only_wr(only), .cfg_overwrite(ow),
    .out_if(if_b), .count(count_b), .full(full_b), .empty(empty_b), .drop_cnt(drop_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
  } ent_t;

  ent_t mq[$];
  int   drops = 0;

  typedef struct {
    logic        hv;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
    logic        ce;
    logic        only;
    logic        ow;
    logic        rdy;
    int          e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rg;
    logic [31:0] e_val;
    int          e_drop;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Model of one clock edge using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    ent_t tmp;
    logic qual;
    qual = hv & ce & (!only | (ena & (rg != 5'd0)));
    e = '{pc: pc, ena: ena, rg: rg, val: val};
    if (mq.size() != 0 && rdy) tmp = mq.pop_front();
    if (qual) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin
        drops++;
        if (ow) begin
          tmp = mq.pop_front();
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic check_all();
    ent_t h;
    int   sz;
    h  = '0;
    sz = mq.size();
    if (sz > 0) h = mq[0];
    chk("count", count_a, sz);
    chk("full", full_a, sz == DEPTH);
    chk("empty", empty_a, sz == 0);
    chk("out_valid", if_a.out_valid, sz != 0);
    chk("out_pc", if_a.out_pc, h.pc);
    chk("out_ena", if_a.out_ena, h.ena);
    chk("out_reg", if_a.out_reg, h.rg);
    chk("out_value", if_a.out_value, h.val);
    chk("drop_cnt", drop_a, (drops > 65535) ? 65535 : drops);
    chk("drop_cnt_sat", drop_b, (drops > 3) ? 3 : drops);
    chk("count_b", count_b, sz);
  endtask

  task automatic cycle(input logic h, input logic [31:0] p, input logic e, input logic [4:0] r,
                       input logic [31:0] v, input logic c, input logic o, input logic w,
                       input logic rd);
    hv = h; pc = p; ena = e; rg = r; val = v; ce = c; only = o; ow = w; rdy = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Called just after a negedge: reset lands between edges and must clear at once.
  task automatic async_reset();
    hv = 1'b0; rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    drops = 0;
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_count", count_a, 0);
    chk("rst_drop_cnt", drop_a, 0);
    chk("rst_drop_cnt_sat", drop_b, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b1, 32'h00, 1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h00, 5'd1, 32'h11, 0};
    vt[1]  = '{1'b1, 32'h04, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h00, 5'd1, 32'h11, 0};
    vt[2]  = '{1'b1, 32'h08, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 32'h00, 5'd1, 32'h11, 0};
    vt[3]  = '{1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 32'h04, 5'd2, 32'h22, 0};
    vt[4]  = '{1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 32'h08, 5'd3, 32'h33, 0};
    vt[5]  = '{1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h00, 5'd0, 32'h00, 0};
    vt[6]  = '{1'b1, 32'h20, 1'b0, 5'd3, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 5'd0, 32'h00, 0};
    vt[7]  = '{1'b1, 32'h24, 1'b1, 5'd0, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 5'd0, 32'h00, 0};
    vt[8]  = '{1'b1, 32'h28, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h28, 5'd5, 32'hDEADBEEF, 0};
    vt[9]  = '{1'b1, 32'h2C, 1'b1, 5'd7, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h28, 5'd5, 32'hDEADBEEF, 0};
    vt[10] = '{1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h00, 5'd0, 32'h00, 0};
    vt[11] = '{1'b1, 32'h30, 1'b0, 5'd0, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h30, 5'd0, 32'h77, 0};
    vt[12] = '{1'b0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h00, 5'd0, 32'h00, 0};

    #1 rst_n = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].hv, vt[i].pc, vt[i].ena, vt[i].rg, vt[i].val, vt[i].ce, vt[i].only,
            vt[i].ow, vt[i].rdy);
      chk($sformatf("vec%0d_count", i), count_a, vt[i].e_count);
      chk($sformatf("vec%0d_valid", i), if_a.out_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_pc", i), if_a.out_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_reg", i), if_a.out_reg, vt[i].e_rg);
      chk($sformatf("vec%0d_value", i), if_a.out_value, vt[i].e_val);
      chk($sformatf("vec%0d_drop", i), drop_a, vt[i].e_drop);
    end

    // Drop-newest: six events into four slots.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(4 * i), 1'b1, 5'd1, 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dn_full", full_a, 1);
    chk("dn_drop_cnt", drop_a, 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dn_head%0d", i), if_a.out_pc, 32'(4 * i));
      cycle(1'b0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    chk("dn_empty", empty_a, 1);

    async_reset();

    // Overwrite-oldest: the same six events keep only the newest four.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(4 * i), 1'b1, 5'd1, 32'(i), 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ow_full", full_a, 1);
    chk("ow_drop_cnt", drop_a, 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ow_head%0d", i), if_a.out_pc, 32'(8 + 4 * i));
      cycle(1'b0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    chk("ow_empty", empty_a, 1);

    async_reset();

    // Full with simultaneous push and pop: order kept, no loss.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b1, 5'd2, 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp_head%0d", i), if_a.out_pc,
          (i < 4) ? 32'h100 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 4)));
      cycle(1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'd2, 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk($sformatf("pp_count%0d", i), count_a, 4);
      chk($sformatf("pp_drop%0d", i), drop_a, 0);
    end

    // Five forced drops: the 2-bit counter holds at 3.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 1'b1, 5'd2, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_drop_cnt", drop_b, 3);
    chk("wide_drop_cnt", drop_a, 5);

    // Reset mid-stream with three entries held, then capture resumes.
    cycle(1'b0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_count", count_a, 3);
    async_reset();
    cycle(1'b1, 32'h300, 1'b1, 5'd9, 32'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_pc", if_a.out_pc, 32'h300);
    chk("resume_count", count_a, 1);

    // Randomized traffic in segments of varying consumer speed and configuration.
    for (int s = 0; s < 15; s++) begin
      int p_rdy;
      logic s_only, s_ow;
      p_rdy  = (s % 3 == 0) ? 10 : ((s % 3 == 1) ? 50 : 90);
      s_only = 1'($urandom_range(0, 1));
      s_ow   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 7) != 0),
              s_only, s_ow, 1'($urandom_range(0, 99) < p_rdy));
      end
      if (s == 7) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised capture FIFO for the CPU's write-back trace port. It sits beside the CPU inside the top level, samples the `debug_wb_*` bus every cycle, and stores qualifying retire events. A bench, UART or JTAG drainer can then read them out at its own pace over a valid/ready handshake. It adds filtering, overwrite-oldest mode, occupancy reporting and a saturating drop counter.

## Interface
Parameters:
- `DEPTH`, 16, entry count; power of two, ≥ 2
- `PC_W`, 32, PC width
- `DATA_W`, 32, write-back value width
- `CNT_W`, 16, drop counter width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `debug_wb_have_inst` in 1: a retire event this cycle
- `debug_wb_pc` in PC_W: PC of retiring instruction
- `debug_wb_ena` in 1: register-file write enable
- `debug_wb_reg` in 5: destination register
- `debug_wb_value` in DATA_W: value written
- `capture_en` in 1: global capture enable
- `cfg_only_wr` in 1: capture only real register writes
- `cfg_overwrite` in 1: 1 = discard oldest when full; 0 = drop newest
- `out_valid` out 1: head entry available
- `out_ready` in 1: consumer accepts head
- `out_pc` out PC_W, `out_ena` out 1, `out_reg` out 5, `out_value` out DATA_W: head entry fields
- `count` out $clog2(DEPTH)+1: occupancy
- `full` out 1, `empty` out 1: occupancy flags
- `drop_cnt` out CNT_W: number of lost events, saturating

## Operation
- Qualify: `q = debug_wb_have_inst & capture_en & (!cfg_only_wr | (debug_wb_ena & debug_wb_reg != 0))`.
- Entry = {pc, ena, reg, value}, stored unmodified.
- Pop: `pop = out_valid & out_ready`. Pop advances the read pointer.
- Push: when `q` and not full, or when `q`, full and `pop`, write at the write pointer and advance it.
- Full with `q` and no `pop`, `cfg_overwrite=0`: new event discarded; `drop_cnt` += 1.
- Full with `q` and no `pop`, `cfg_overwrite=1`: the oldest entry is discarded. Read and write pointers both advance, the new entry is written, `count` stays DEPTH, and `drop_cnt` += 1.
- Full with `q` and `pop`: both succeed, no drop, `count` unchanged.
- `drop_cnt` saturates at 2^CNT_W−1 and never wraps.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked explicitly, so full = (count == DEPTH) and empty = (count == 0).
- Output data is gated: `out_pc`, `out_ena`, `out_reg` and `out_value` are 0 whenever `out_valid` = 0.
- Handshake: while `out_valid=1` and `out_ready=0`, the head entry stays stable. The one exception is an overwrite-mode discard, where the head is the entry being replaced.
- Changing `cfg_*` or `capture_en` takes effect on the next edge. It never flushes stored entries.

## Timing
- Reset (`rst_n`=0, asynchronous): pointers 0, `count`=0, `empty`=1, `full`=0, `drop_cnt`=0, `out_valid`=0, all `out_*` data 0. Storage array is not reset.
- Reset asserted mid-operation clears all state immediately; entries are lost and not counted as drops.
- Latency: an event qualified at edge N appears at the head (if the FIFO was empty) with `out_valid`=1 in the cycle after edge N. There is no same-cycle fall-through.
- `count`, `full`, `empty`, `drop_cnt` and `out_valid` are registered state or direct decodes of it, with no combinational path from inputs.
- `out_valid` and the `out_*` data depend only on state. `out_ready` does not feed `out_valid` combinationally.
- Push and pop in the same cycle when not full and not empty: `count` is unchanged.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset/basic: `DEPTH=4`. Push 3 events with pc 0x00,0x04,0x08 while `out_ready=0` → `count`=3. Then set `out_ready=1` → entries read in order, one per cycle; `empty`=1 after the third pop; `drop_cnt`=0.
- Filter: `cfg_only_wr=1`. Send events {ena=0}, {ena=1, reg=0}, {ena=1, reg=5, value=0xDEADBEEF} → only the reg=5 entry is stored (`count`=1). The head shows reg=5, value=0xDEADBEEF.
- Drop-newest: `DEPTH=4`, `cfg_overwrite=0`, `out_ready=0`. Push 6 events pc 0..0x14 → `full`=1, `drop_cnt`=2. The drain yields pcs 0x00,0x04,0x08,0x0C.
- Overwrite-oldest: same stimulus with `cfg_overwrite=1` → `drop_cnt`=2. The drain yields 0x08,0x0C,0x10,0x14.
- Full with simultaneous push/pop: hold the FIFO full, then assert `q` and `out_ready` together for 10 cycles → `count` stays 4, `drop_cnt` unchanged, output order preserved. Also set `CNT_W=2` and force 5 drops → `drop_cnt` holds at 3.
- Async reset mid-stream: assert `rst_n`=0 between edges with `count`=3 → `out_valid`, `count` and `drop_cnt` go to 0 immediately, before the next clock edge. Capture resumes normally after release.
